// File: rtl/exception_unit.sv
// Exception controller for the single-cycle LEGv8 core: tracks NORMAL/HANDLER/FAULT mode,
// captures ELR/ESR/ECNT on exception entry, redirects fetch and serves the registers to MRS.
module exception_unit #(
  parameter int           N      = 64,
  parameter logic [N-1:0] VECTOR = 64'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] imem_addr_F,
  input  logic [N-1:0] NextPC,
  input  logic [1:0]   SysRegSel,
  output logic [N-1:0] SysRegData,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic [N-1:0] ELR_out,
  output logic         InHandler,
  output logic         ExtAck,
  output logic         Halt
);

  typedef enum logic [1:0] {
    S_NORMAL  = 2'd0,
    S_HANDLER = 2'd1,
    S_FAULT   = 2'd2
  } state_e;

  localparam logic [3:0] ESR_IRQ = 4'b0001;
  localparam logic [7:0] ECNT_MAX = 8'hFF;

  state_e       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic [7:0]   ecnt_q, ecnt_d;
  logic         ack_q, ack_d;

  logic         sync_exc;
  logic         irq_take;
  logic [7:0]   ecnt_inc;

  // A synchronous exception always beats the interrupt; IRQs are only seen in NORMAL.
  assign sync_exc = (EStatus != 4'b0000);
  assign irq_take = (state_q == S_NORMAL) && !sync_exc && ExtIRQ;
  assign ecnt_inc = (ecnt_q == ECNT_MAX) ? ecnt_q : ecnt_q + 8'd1;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NORMAL: begin
        if (sync_exc || ExtIRQ) state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (sync_exc)  state_d = S_FAULT;
        else if (ERet) state_d = S_NORMAL;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_NORMAL;
    endcase
  end

  // System register update logic
  always_comb begin
    elr_d  = elr_q;
    esr_d  = esr_q;
    ecnt_d = ecnt_q;
    ack_d  = 1'b0;
    case (state_q)
      S_NORMAL: begin
        if (sync_exc) begin
          elr_d  = imem_addr_F;
          esr_d  = EStatus;
          ecnt_d = ecnt_inc;
        end else if (irq_take) begin
          elr_d  = NextPC;
          esr_d  = ESR_IRQ;
          ecnt_d = ecnt_inc;
          ack_d  = 1'b1;
        end
      end
      S_HANDLER: begin
        // Nested fault records the new syndrome but keeps the original return address.
        if (sync_exc) esr_d = EStatus;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr_q  <= '0;
      esr_q  <= '0;
      ecnt_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      elr_q  <= elr_d;
      esr_q  <= esr_d;
      ecnt_q <= ecnt_d;
      ack_q  <= ack_d;
    end
  end

  // Output logic
  always_comb begin
    Exc       = 1'b0;
    InHandler = 1'b0;
    Halt      = 1'b0;
    case (state_q)
      S_NORMAL:  Exc       = sync_exc || ExtIRQ;
      S_HANDLER: InHandler = 1'b1;
      S_FAULT:   Halt      = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    SysRegData = '0;
    case (SysRegSel)
      2'b00:   SysRegData = elr_q;
      2'b01:   SysRegData = {{(N-4){1'b0}}, esr_q};
      2'b10:   SysRegData = {{(N-8){1'b0}}, ecnt_q};
      default: SysRegData = '0;
    endcase
  end

  assign ExcVector = VECTOR;
  assign ELR_out   = elr_q;
  assign ExtAck    = ack_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit: entry, IRQ, return, nested fault,
// priority, counter saturation and asynchronous reset.
module tb_exception_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  EStatus;
  logic        ERet;
  logic        ExtIRQ;
  logic [63:0] imem_addr_F;
  logic [63:0] NextPC;
  logic [1:0]  SysRegSel;
  logic [63:0] SysRegData;
  logic        Exc;
  logic [63:0] ExcVector;
  logic [63:0] ELR_out;
  logic        InHandler;
  logic        ExtAck;
  logic        Halt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] v;

  exception_unit #(.N(64), .VECTOR(64'hD8)) dut (
    .clk(clk), .reset(reset), .EStatus(EStatus), .ERet(ERet), .ExtIRQ(ExtIRQ),
    .imem_addr_F(imem_addr_F), .NextPC(NextPC), .SysRegSel(SysRegSel),
    .SysRegData(SysRegData), .Exc(Exc), .ExcVector(ExcVector), .ELR_out(ELR_out),
    .InHandler(InHandler), .ExtAck(ExtAck), .Halt(Halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] es, input logic er, input logic irq,
                       input logic [63:0] pc, input logic [63:0] npc);
    EStatus = es; ERet = er; ExtIRQ = irq; imem_addr_F = pc; NextPC = npc;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [63:0] val);
    SysRegSel = sel;
    #1;
    val = SysRegData;
  endtask

  task automatic test_reset();
    drive(4'd0, 1'b0, 1'b0, 64'h0, 64'h4);
    reset = 1'b0;
    #3;
    n_checks++; if (Exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", Exc); end
    n_checks++; if (Halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b expected 0", Halt); end
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL reset_inhandler: got %b expected 0", InHandler); end
    n_checks++; if (ExtAck !== 1'b0) begin n_fail++; $display("FAIL reset_extack: got %b expected 0", ExtAck); end
    n_checks++; if (ExcVector !== 64'hD8) begin n_fail++; $display("FAIL reset_vector: got %h expected d8", ExcVector); end
    rd(2'b00, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL reset_elr: got %h expected 0", v); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL reset_esr: got %h expected 0", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL reset_ecnt: got %h expected 0", v); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_invalid_opcode();
    drive(4'b0010, 1'b0, 1'b0, 64'h40, 64'h44);
    #1;
    n_checks++; if (Exc !== 1'b1) begin n_fail++; $display("FAIL inv_exc: got %b expected 1", Exc); end
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'hD8, 64'hDC);
    n_checks++; if (InHandler !== 1'b1) begin n_fail++; $display("FAIL inv_inhandler: got %b expected 1", InHandler); end
    n_checks++; if (ELR_out !== 64'h40) begin n_fail++; $display("FAIL inv_elr_out: got %h expected 40", ELR_out); end
    rd(2'b00, v);
    n_checks++; if (v !== 64'h40) begin n_fail++; $display("FAIL inv_mrs_elr: got %h expected 40", v); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL inv_esr: got %h expected 2", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h1) begin n_fail++; $display("FAIL inv_ecnt: got %h expected 1", v); end
    rd(2'b11, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL inv_sel11: got %h expected 0", v); end
    // ERET back to NORMAL
    drive(4'd0, 1'b1, 1'b0, 64'hDC, 64'h40);
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'h40, 64'h44);
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL inv_ret_inhandler: got %b expected 0", InHandler); end
    n_checks++; if (ELR_out !== 64'h40) begin n_fail++; $display("FAIL inv_ret_elr: got %h expected 40", ELR_out); end
  endtask

  task automatic test_irq_and_return();
    drive(4'd0, 1'b0, 1'b1, 64'h20, 64'h24);
    #1;
    n_checks++; if (Exc !== 1'b1) begin n_fail++; $display("FAIL irq_exc: got %b expected 1", Exc); end
    n_checks++; if (ExtAck !== 1'b0) begin n_fail++; $display("FAIL irq_ack_early: got %b expected 0", ExtAck); end
    cyc();
    drive(4'd0, 1'b0, 1'b1, 64'hD8, 64'hDC);
    n_checks++; if (ExtAck !== 1'b1) begin n_fail++; $display("FAIL irq_ack: got %b expected 1", ExtAck); end
    n_checks++; if (InHandler !== 1'b1) begin n_fail++; $display("FAIL irq_inhandler: got %b expected 1", InHandler); end
    n_checks++; if (Exc !== 1'b0) begin n_fail++; $display("FAIL irq_masked_exc: got %b expected 0", Exc); end
    rd(2'b00, v);
    n_checks++; if (v !== 64'h24) begin n_fail++; $display("FAIL irq_elr: got %h expected 24", v); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h1) begin n_fail++; $display("FAIL irq_esr: got %h expected 1", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL irq_ecnt: got %h expected 2", v); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++; if (ExtAck !== 1'b0) begin n_fail++; $display("FAIL irq_no_second_ack[%0d]: got %b expected 0", i, ExtAck); end
    end
    // ERET with the line still high: next NORMAL cycle retakes it
    drive(4'd0, 1'b1, 1'b1, 64'hE0, 64'h24);
    #1;
    n_checks++; if (Exc !== 1'b0) begin n_fail++; $display("FAIL ret_exc: got %b expected 0", Exc); end
    cyc();
    drive(4'd0, 1'b0, 1'b1, 64'h24, 64'h30);
    #1;
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL ret_inhandler: got %b expected 0", InHandler); end
    n_checks++; if (ELR_out !== 64'h24) begin n_fail++; $display("FAIL ret_elr: got %h expected 24", ELR_out); end
    n_checks++; if (Exc !== 1'b1) begin n_fail++; $display("FAIL retake_exc: got %b expected 1", Exc); end
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'hD8, 64'hDC);
    n_checks++; if (ExtAck !== 1'b1) begin n_fail++; $display("FAIL retake_ack: got %b expected 1", ExtAck); end
    n_checks++; if (ELR_out !== 64'h30) begin n_fail++; $display("FAIL retake_elr: got %h expected 30", ELR_out); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h3) begin n_fail++; $display("FAIL retake_ecnt: got %h expected 3", v); end
    drive(4'd0, 1'b1, 1'b0, 64'hDC, 64'h30);
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'h30, 64'h34);
  endtask

  task automatic test_priority();
    drive(4'b0010, 1'b0, 1'b1, 64'h80, 64'h84);
    #1;
    n_checks++; if (Exc !== 1'b1) begin n_fail++; $display("FAIL prio_exc: got %b expected 1", Exc); end
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'hD8, 64'hDC);
    n_checks++; if (ExtAck !== 1'b0) begin n_fail++; $display("FAIL prio_ack: got %b expected 0", ExtAck); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL prio_esr: got %h expected 2", v); end
    rd(2'b00, v);
    n_checks++; if (v !== 64'h80) begin n_fail++; $display("FAIL prio_elr: got %h expected 80", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h4) begin n_fail++; $display("FAIL prio_ecnt: got %h expected 4", v); end
    drive(4'd0, 1'b1, 1'b0, 64'hDC, 64'h80);
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'h80, 64'h84);
  endtask

  task automatic test_nested_fault();
    drive(4'b0011, 1'b0, 1'b0, 64'h100, 64'h104);
    cyc();
    drive(4'b0010, 1'b0, 1'b0, 64'hD8, 64'hDC);
    #1;
    n_checks++; if (Exc !== 1'b0) begin n_fail++; $display("FAIL nest_exc: got %b expected 0", Exc); end
    cyc();
    drive(4'd5, 1'b1, 1'b1, 64'hDC, 64'hE0);
    n_checks++; if (Halt !== 1'b1) begin n_fail++; $display("FAIL nest_halt: got %b expected 1", Halt); end
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL nest_inhandler: got %b expected 0", InHandler); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL nest_esr: got %h expected 2", v); end
    rd(2'b00, v);
    n_checks++; if (v !== 64'h100) begin n_fail++; $display("FAIL nest_elr: got %h expected 100", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h5) begin n_fail++; $display("FAIL nest_ecnt: got %h expected 5", v); end
    n_checks++; if (Exc !== 1'b0) begin n_fail++; $display("FAIL fault_exc: got %b expected 0", Exc); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (Halt !== 1'b1 || ExtAck !== 1'b0) begin
        n_fail++; $display("FAIL fault_sticky[%0d]: got halt=%b ack=%b expected halt=1 ack=0", i, Halt, ExtAck);
      end
    end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h2) begin n_fail++; $display("FAIL fault_esr_hold: got %h expected 2", v); end
    drive(4'd0, 1'b0, 1'b0, 64'h0, 64'h4);
    reset = 1'b0;
    #1;
    n_checks++; if (Halt !== 1'b0) begin n_fail++; $display("FAIL fault_reset_halt: got %b expected 0", Halt); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 260; i++) begin
      drive(4'b0001, 1'b0, 1'b0, 64'h200, 64'h204);
      cyc();
      drive(4'd0, 1'b1, 1'b0, 64'hD8, 64'h200);
      cyc();
      if (i == 255) begin
        rd(2'b10, v);
        n_checks++; if (v !== 64'hFF) begin n_fail++; $display("FAIL sat_ecnt_255: got %h expected ff", v); end
      end
    end
    drive(4'd0, 1'b0, 1'b0, 64'h200, 64'h204);
    rd(2'b10, v);
    n_checks++; if (v !== 64'hFF) begin n_fail++; $display("FAIL sat_ecnt_260: got %h expected ff", v); end
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL sat_state: got %b expected 0", InHandler); end
  endtask

  task automatic test_async_reset();
    // Mid-handler reset, between edges
    drive(4'b0010, 1'b0, 1'b0, 64'h40, 64'h44);
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'hD8, 64'hDC);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL arst_inhandler: got %b expected 0", InHandler); end
    n_checks++; if (ELR_out !== 64'h0) begin n_fail++; $display("FAIL arst_elr_out: got %h expected 0", ELR_out); end
    rd(2'b01, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL arst_esr: got %h expected 0", v); end
    rd(2'b10, v);
    n_checks++; if (v !== 64'h0) begin n_fail++; $display("FAIL arst_ecnt: got %h expected 0", v); end
    @(negedge clk);
    reset = 1'b1;
    // Reset during the ExtAck pulse
    drive(4'd0, 1'b0, 1'b1, 64'h60, 64'h64);
    cyc();
    drive(4'd0, 1'b0, 1'b0, 64'hD8, 64'hDC);
    n_checks++; if (ExtAck !== 1'b1) begin n_fail++; $display("FAIL arst_ack_pre: got %b expected 1", ExtAck); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (ExtAck !== 1'b0) begin n_fail++; $display("FAIL arst_ack: got %b expected 0", ExtAck); end
    n_checks++; if (InHandler !== 1'b0) begin n_fail++; $display("FAIL arst_irq_state: got %b expected 0", InHandler); end
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    SysRegSel = 2'b00;
    test_reset();
    test_invalid_opcode();
    test_irq_and_return();
    test_priority();
    test_nested_fault();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
